// File: rtl/pulse_sequencer_if.sv
// Bus between the host/ns_timer side and the pulse sequencer: table programming,
// run control, timer coupling and the gated output pattern.
interface pulse_sequencer_if #(
  parameter int ADDR_W = 4,
  parameter int OUT_W  = 8,
  parameter int TW     = 64
);
  logic [TW-1:0]     time_elaps;
  logic              timer_reset;
  logic              cfg_we;
  logic [ADDR_W-1:0] cfg_addr;
  logic [TW-1:0]     cfg_time;
  logic [OUT_W-1:0]  cfg_out;
  logic [ADDR_W:0]   n_events;
  logic              start;
  logic              abort;
  logic              busy;
  logic              done;
  logic [OUT_W-1:0]  seq_out;
  logic [ADDR_W-1:0] event_idx;

  modport master (
    output time_elaps, cfg_we, cfg_addr, cfg_time, cfg_out, n_events, start, abort,
    input  timer_reset, busy, done, seq_out, event_idx
  );

  modport slave (
    input  time_elaps, cfg_we, cfg_addr, cfg_time, cfg_out, n_events, start, abort,
    output timer_reset, busy, done, seq_out, event_idx
  );
endinterface

// File: rtl/pulse_sequencer.sv
// Timed event scheduler: holds ns_timer in reset until a run starts, then applies
// each table pattern to seq_out once the elapsed tick count reaches its time stamp.
module pulse_sequencer #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4,
  parameter int OUT_W  = 8,
  parameter int TW     = 64
) (
  input  logic             clk,
  input  logic             reset,
  pulse_sequencer_if.slave bus
);
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ARM  = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [ADDR_W:0] LP_DEPTH = (ADDR_W+1)'(DEPTH);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [TW-1:0]     r_tab_time [DEPTH];
  logic [OUT_W-1:0]  r_tab_out  [DEPTH];
  logic [OUT_W-1:0]  r_seq_out;
  logic [OUT_W-1:0]  w_seq_nxt;
  logic [ADDR_W-1:0] r_event_idx;
  logic [ADDR_W-1:0] w_idx_nxt;
  logic [ADDR_W-1:0] r_last_idx;
  logic [ADDR_W-1:0] w_last_nxt;
  logic              r_busy;
  logic              r_done;
  logic              r_timer_reset;
  logic [ADDR_W:0]   w_n_clamp;
  logic [ADDR_W-1:0] w_n_last;
  logic              w_due;

  assign w_n_clamp = (bus.n_events > LP_DEPTH) ? LP_DEPTH : bus.n_events;
  assign w_n_last  = ADDR_W'(w_n_clamp - (ADDR_W+1)'(1));
  assign w_due     = (bus.time_elaps >= r_tab_time[r_event_idx]);

  // Table is writable only while idle so a running sequence never changes under us.
  always_ff @(posedge clk) begin
    if (bus.cfg_we && (r_state == S_IDLE)) begin
      r_tab_time[bus.cfg_addr] <= bus.cfg_time;
      r_tab_out[bus.cfg_addr]  <= bus.cfg_out;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_seq_nxt   = r_seq_out;
    w_idx_nxt   = r_event_idx;
    w_last_nxt  = r_last_idx;
    case (r_state)
      S_IDLE: begin
        w_idx_nxt = '0;
        if (bus.abort) begin
          w_seq_nxt = '0;
        end else if (bus.start && (w_n_clamp != '0)) begin
          w_state_nxt = S_ARM;
          w_seq_nxt   = '0;
          w_last_nxt  = w_n_last;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_ARM: begin
        if (bus.abort) begin
          w_state_nxt = S_IDLE;
          w_seq_nxt   = '0;
          w_idx_nxt   = '0;
        end else begin
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        // Abort outranks an event that is due on the same edge.
        if (bus.abort) begin
          w_state_nxt = S_IDLE;
          w_seq_nxt   = '0;
          w_idx_nxt   = '0;
        end else if (w_due) begin
          w_seq_nxt = r_tab_out[r_event_idx];
          if (r_event_idx == r_last_idx) begin
            w_state_nxt = S_DONE;
          end else begin
            w_idx_nxt = r_event_idx + ADDR_W'(1);
          end
        end else begin
          w_state_nxt = S_RUN;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
        w_idx_nxt   = '0;
        if (bus.abort) begin
          w_seq_nxt = '0;
        end else begin
          w_seq_nxt = r_seq_out;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_seq_nxt   = '0;
        w_idx_nxt   = '0;
      end
    endcase
  end

  // Status outputs are registered from the next state so they line up with r_state.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_seq_out     <= '0;
      r_event_idx   <= '0;
      r_last_idx    <= '0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_timer_reset <= 1'b1;
    end else begin
      r_seq_out     <= w_seq_nxt;
      r_event_idx   <= w_idx_nxt;
      r_last_idx    <= w_last_nxt;
      r_busy        <= (w_state_nxt == S_ARM) || (w_state_nxt == S_RUN);
      r_done        <= (w_state_nxt == S_DONE);
      r_timer_reset <= (w_state_nxt != S_RUN);
    end
  end

  assign bus.seq_out     = r_seq_out;
  assign bus.event_idx   = r_event_idx;
  assign bus.busy        = r_busy;
  assign bus.done        = r_done;
  assign bus.timer_reset = r_timer_reset;
endmodule

// File: tb/tb_pulse_sequencer.sv
// Bench for pulse_sequencer: models ns_timer, predicts each event's firing tick and
// pattern into a scoreboard, and a monitor pops and compares as events are applied.
module tb_pulse_sequencer;
  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;
  localparam int OUT_W  = 8;
  localparam int TW     = 64;

  typedef struct {
    longint           t;
    logic [OUT_W-1:0] pat;
    int               idx;
  } ev_t;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  pulse_sequencer_if #(.ADDR_W(ADDR_W), .OUT_W(OUT_W), .TW(TW)) bus ();

  pulse_sequencer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .OUT_W(OUT_W), .TW(TW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int               n_checks = 0;
  int               n_pass   = 0;
  int               done_cnt = 0;
  logic             mon_en   = 1'b0;
  ev_t              sb[$];
  longint           m_time [DEPTH];
  logic [OUT_W-1:0] m_out  [DEPTH];
  logic [ADDR_W-1:0] prev_idx;
  logic             prev_done;
  logic [TW-1:0]    prev_t;

  // ns_timer model: zero while its reset is asserted, +1 per clock otherwise.
  always @(posedge clk) begin
    if (bus.timer_reset !== 1'b0) bus.time_elaps <= '0;
    else bus.time_elaps <= bus.time_elaps + 64'd1;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: observed 0x%0h, required 0x%0h", tag, obs, exp);
  endtask

  // An event was applied at the last edge if event_idx stepped by one or done rose.
  always @(negedge clk) begin : mon
    ev_t  e;
    logic fired;
    if (mon_en) begin
      fired = (bus.done && !prev_done) ||
              ({1'b0, bus.event_idx} == ({1'b0, prev_idx} + 5'd1));
      if (fired) begin
        chk("sb_has_entry", (sb.size() != 0), 1'b1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk("ev_pattern", bus.seq_out, e.pat);
          chk("ev_time", prev_t, e.t);
          chk("ev_index", prev_idx, e.idx);
        end
      end
      if (bus.done) begin
        done_cnt++;
        chk("done_width", prev_done, 1'b0);
      end
    end
    prev_idx  <= bus.event_idx;
    prev_done <= bus.done;
    prev_t    <= bus.time_elaps;
  end

  task automatic wr_ev(input int a, input longint t, input logic [OUT_W-1:0] p);
    @(negedge clk);
    bus.cfg_we   = 1'b1;
    bus.cfg_addr = ADDR_W'(a);
    bus.cfg_time = TW'(t);
    bus.cfg_out  = p;
    m_time[a]    = t;
    m_out[a]     = p;
    @(negedge clk);
    bus.cfg_we   = 1'b0;
  endtask

  task automatic run_seq(input int n, input longint abort_t, input bit we_mid,
                         input bit wr, input int wa, input longint wt, input logic [OUT_W-1:0] wp);
    int     nc;
    int     d0;
    longint c;
    longint f;
    bit     finished;
    bit     aborted;
    ev_t    e;
    nc       = (n > DEPTH) ? DEPTH : n;
    c        = -1;
    finished = 1'b0;
    aborted  = 1'b0;
    d0       = done_cnt;
    if (wr) begin
      m_time[wa] = wt;
      m_out[wa]  = wp;
    end
    for (int i = 0; i < nc; i++) begin
      f = (m_time[i] > c) ? m_time[i] : c + 1;
      c = f;
      if (abort_t < 0 || f < abort_t) begin
        e.t = f; e.pat = m_out[i]; e.idx = i;
        sb.push_back(e);
      end
    end
    @(negedge clk);
    bus.n_events = (ADDR_W+1)'(n);
    bus.start    = 1'b1;
    if (wr) begin
      bus.cfg_we   = 1'b1;
      bus.cfg_addr = ADDR_W'(wa);
      bus.cfg_time = TW'(wt);
      bus.cfg_out  = wp;
    end
    @(negedge clk);
    bus.start  = 1'b0;
    bus.cfg_we = 1'b0;
    chk("arm_busy", bus.busy, 1'b1);
    chk("arm_timer_reset", bus.timer_reset, 1'b1);
    if (we_mid) begin
      bus.cfg_addr = 4'd1;
      bus.cfg_time = 64'd12;
      bus.cfg_out  = 8'h7E;
    end
    for (int k = 0; k < 400 && !finished; k++) begin
      @(negedge clk);
      if (bus.done) begin
        chk("done_busy", bus.busy, 1'b0);
        chk("done_timer_reset", bus.timer_reset, 1'b1);
        finished = 1'b1;
      end else begin
        chk("run_busy", bus.busy, 1'b1);
        chk("run_timer_reset", bus.timer_reset, 1'b0);
        bus.cfg_we = we_mid && (bus.time_elaps == 64'd5);
        if (abort_t >= 0 && bus.time_elaps == TW'(abort_t)) begin
          bus.abort = 1'b1;
          aborted   = 1'b1;
          finished  = 1'b1;
        end
      end
    end
    bus.cfg_we = 1'b0;
    chk("run_finished", finished, 1'b1);
    @(negedge clk);
    bus.abort = 1'b0;
    if (aborted) begin
      chk("abort_seq_out", bus.seq_out, 8'h00);
      chk("abort_timer_reset", bus.timer_reset, 1'b1);
      chk("abort_done", bus.done, 1'b0);
    end else begin
      chk("done_once", bus.done, 1'b0);
      chk("hold_seq_out", bus.seq_out, m_out[nc-1]);
    end
    chk("idle_busy", bus.busy, 1'b0);
    chk("idle_event_idx", bus.event_idx, 4'd0);
    chk("sb_drained", sb.size(), 0);
    chk("done_count", done_cnt - d0, aborted ? 0 : 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset        = 1'b1;
    bus.cfg_we   = 1'b0;
    bus.cfg_addr = '0;
    bus.cfg_time = '0;
    bus.cfg_out  = '0;
    bus.n_events = '0;
    bus.start    = 1'b0;
    bus.abort    = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_seq_out", bus.seq_out, 8'h00);
    chk("rst_event_idx", bus.event_idx, 4'd0);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_done", bus.done, 1'b0);
    chk("rst_timer_reset", bus.timer_reset, 1'b1);
    reset  = 1'b0;
    mon_en = 1'b1;

    wr_ev(0, 10, 8'h01);
    wr_ev(1, 20, 8'h03);
    wr_ev(2, 35, 8'h00);
    run_seq(3, -1, 1'b0, 1'b0, 0, 0, 8'h00);
    // A write attempted mid-run must be dropped.
    run_seq(3, -1, 1'b1, 1'b0, 0, 0, 8'h00);
    run_seq(3, 15, 1'b0, 1'b0, 0, 0, 8'h00);
    run_seq(3, -1, 1'b0, 1'b0, 0, 0, 8'h00);

    // Reset in the middle of a run.
    sb.push_back('{t: 10, pat: 8'h01, idx: 0});
    @(negedge clk);
    bus.n_events = 5'd3;
    bus.start    = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (bus.time_elaps == 64'd12) break;
    end
    chk("mid_reset_reached", bus.time_elaps, 64'd12);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("mid_reset_seq_out", bus.seq_out, 8'h00);
    chk("mid_reset_event_idx", bus.event_idx, 4'd0);
    chk("mid_reset_busy", bus.busy, 1'b0);
    chk("mid_reset_timer_reset", bus.timer_reset, 1'b1);
    chk("mid_reset_sb", sb.size(), 0);

    wr_ev(0, 5, 8'hAA);
    wr_ev(1, 5, 8'h55);
    run_seq(2, -1, 1'b0, 1'b0, 0, 0, 8'h00);
    run_seq(1, -1, 1'b0, 1'b1, 0, 0, 8'hFF);

    // start together with abort: abort wins and clears the held pattern.
    @(negedge clk);
    bus.n_events = 5'd3;
    bus.start    = 1'b1;
    bus.abort    = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.abort = 1'b0;
    chk("start_abort_seq_out", bus.seq_out, 8'h00);
    chk("start_abort_busy", bus.busy, 1'b0);
    @(negedge clk);
    chk("start_abort_busy2", bus.busy, 1'b0);
    chk("start_abort_timer_reset", bus.timer_reset, 1'b1);

    @(negedge clk);
    bus.n_events = 5'd0;
    bus.start    = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    chk("zero_n_busy", bus.busy, 1'b0);
    @(negedge clk);
    chk("zero_n_busy2", bus.busy, 1'b0);
    chk("zero_n_timer_reset", bus.timer_reset, 1'b1);

    // n_events beyond the table depth runs the full table.
    for (int i = 0; i < DEPTH; i++) wr_ev(i, longint'(i) * 3, 8'(8'h10 + i));
    run_seq(20, -1, 1'b0, 1'b0, 0, 0, 8'h00);

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
